// File: rtl/stack_engine.sv
// stack_engine: sequential PUSH/POP and CALL/RET stack transfers against a
// 16-bit-word data memory. Owns the architectural SP (grows downward, points
// at the next free word). 32-bit values move as two 16-bit accesses.
module stack_engine #(
    parameter logic [31:0] SP_INIT  = 32'h000F_FFFF,
    parameter logic [31:0] SP_LIMIT = 32'h000F_F000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_pop,
    input  logic        req_two,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_data,
    output logic [31:0] sp_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC1 = 2'd1, ACC2 = 2'd2, RESP = 2'd3} state_t;

    // Latched request; only the low push half is needed after ACC1 is issued.
    typedef struct packed {
        logic        pop;
        logic        two;
        logic [15:0] wlo;
    } req_t;

    state_t      state, state_nx;
    req_t        req_q;
    logic [31:0] sp;
    logic [31:0] step;
    logic [15:0] lo_q;
    logic        accept, ack, legal, push_ok, pop_ok;
    logic [32:0] n_ext;

    assign accept = req_valid && req_ready;
    assign ack    = mem_req && mem_ack;
    assign n_ext  = req_two ? 33'd2 : 33'd1;
    assign step   = req_q.two ? 32'd2 : 32'd1;
    assign sp_out = sp;

    // SP-(n-1) >= LIMIT rewritten as SP+1 >= LIMIT+n; 33 bits so nothing wraps
    assign push_ok = ({1'b0, sp} + 33'd1) >= ({1'b0, SP_LIMIT} + n_ext);
    assign pop_ok  = ({1'b0, sp} + n_ext) <= {1'b0, SP_INIT};
    assign legal   = req_pop ? pop_ok : push_ok;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = legal ? ACC1 : RESP;
            ACC1: if (ack)    state_nx = req_q.two ? ACC2 : RESP;
            ACC2: if (ack)    state_nx = RESP;
            RESP:             state_nx = IDLE;
            default:          state_nx = IDLE;
        endcase
    end

    // State-decoded handshake outputs
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    // Datapath: registered memory port, response payload and SP
    always_ff @(posedge clk) begin
        if (!rst) begin
            sp        <= SP_INIT;
            req_q     <= '0;
            lo_q      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    req_q    <= '{pop: req_pop, two: req_two, wlo: req_wdata[15:0]};
                    rsp_err  <= !legal;
                    rsp_data <= '0;
                    if (legal) begin
                        // First access: push writes at SP (high half if two words),
                        // pop reads the top word at SP+1.
                        mem_req   <= 1'b1;
                        mem_we    <= !req_pop;
                        mem_addr  <= req_pop ? sp + 32'd1 : sp;
                        mem_wdata <= req_pop ? 16'h0 : (req_two ? req_wdata[31:16] : req_wdata[15:0]);
                    end
                end
                ACC1: if (ack) begin
                    if (req_q.two) begin
                        // Re-drive the second access with no gap in mem_req
                        lo_q      <= mem_rdata;
                        mem_addr  <= req_q.pop ? mem_addr + 32'd1 : mem_addr - 32'd1;
                        mem_wdata <= req_q.pop ? 16'h0 : req_q.wlo;
                    end else begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        rsp_data <= req_q.pop ? {16'h0, mem_rdata} : 32'h0;
                    end
                end
                ACC2: if (ack) begin
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                    rsp_data <= req_q.pop ? {mem_rdata, lo_q} : 32'h0;
                end
                RESP: begin
                    if (!rsp_err) sp <= req_q.pop ? sp + step : sp - step;
                    rsp_err  <= 1'b0;
                    rsp_data <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: randomized and directed checks of stack_engine against a
// word-queue stack model with a configurable-latency memory responder.
module tb_stack_engine;

    localparam logic [31:0] SP_INIT  = 32'h0000_03FF;
    localparam logic [31:0] SP_LIMIT = 32'h0000_03F0;
    localparam int          CAP      = 16;

    logic        clk, rst;
    logic        req_valid, req_ready, req_pop, req_two;
    logic [31:0] req_wdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data, sp_out;

    stack_engine #(.SP_INIT(SP_INIT), .SP_LIMIT(SP_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_pop(req_pop),
        .req_two(req_two), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .sp_out(sp_out)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [15:0] data;
    } acc_t;

    typedef struct {
        bit          pop;
        bit          two;
        logic [31:0] wd;
        bit          e_err;
        logic [31:0] e_data;
        logic [31:0] e_sp;
    } dir_t;

    acc_t        act_log[$];
    acc_t        exp_log[$];
    logic [15:0] mem[logic [31:0]];
    logic [15:0] ref_stack[$];   // front = top of stack
    int          errors = 0;
    int          checks = 0;
    int          wait_cfg = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory responder: acks after wait_cfg idle cycles of each access
    initial begin : responder
        int cnt;
        cnt = 0; mem_ack = 0; mem_rdata = 0;
        forever begin
            @(posedge clk); #2;
            mem_ack = 0;
            if (mem_req && rst) begin
                if (cnt >= wait_cfg) begin
                    mem_ack = 1;
                    cnt = 0;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'h0;
                    act_log.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
                end else cnt++;
            end else cnt = 0;
        end
    end

    // Reference model: stack of words, capacity from the window size
    task automatic model_op(input bit pop, input bit two, input logic [31:0] wd, input int w,
                            output bit e_err, output logic [31:0] e_data, output int e_lat);
        int          n;
        int          depth;
        logic [31:0] sp;
        logic [15:0] lo, hi;
        n = two ? 2 : 1;
        depth = ref_stack.size();
        sp = SP_INIT - 32'(depth);
        exp_log.delete();
        e_err = 0; e_data = 0;
        if (pop) begin
            if (depth < n) e_err = 1;
            else begin
                lo = ref_stack.pop_front();
                exp_log.push_back('{1'b0, sp + 32'd1, lo});
                if (two) begin
                    hi = ref_stack.pop_front();
                    exp_log.push_back('{1'b0, sp + 32'd2, hi});
                    e_data = {hi, lo};
                end else e_data = {16'h0, lo};
            end
        end else begin
            if (depth + n > CAP) e_err = 1;
            else if (two) begin
                exp_log.push_back('{1'b1, sp, wd[31:16]});
                exp_log.push_back('{1'b1, sp - 32'd1, wd[15:0]});
                ref_stack.push_front(wd[31:16]);
                ref_stack.push_front(wd[15:0]);
            end else begin
                exp_log.push_back('{1'b1, sp, wd[15:0]});
                ref_stack.push_front(wd[15:0]);
            end
        end
        e_lat = e_err ? 1 : 1 + n * (w + 1);
    endtask

    // Drive one request from a negedge with the engine idle; returns at a negedge
    task automatic run_op(input bit pop, input bit two, input logic [31:0] wd, input int w,
                          output int lat, output logic err, output logic [31:0] data,
                          output bit saw, output logic [31:0] sp_after, output logic rdy_after);
        bit done;
        done = 0; lat = -1; err = 0; data = 0; saw = 0;
        wait_cfg = w;
        act_log.delete();
        req_valid = 1; req_pop = pop; req_two = two; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0;
        for (int c = 1; c <= 100 && !done; c++) begin
            @(negedge clk);
            if (mem_req) saw = 1;
            if (rsp_valid) begin
                done = 1; lat = c; err = rsp_err; data = rsp_data;
            end else @(posedge clk);
        end
        @(negedge clk);
        sp_after = sp_out;
        rdy_after = req_ready;
    endtask

    task automatic test_reset();
        rst = 0; req_valid = 0; req_pop = 0; req_two = 0; req_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
            errors++;
            $display("FAIL reset_mem: req=%0b we=%0b addr=%h wdata=%h, want all 0", mem_req, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (rsp_valid !== 0 || rsp_err !== 0 || rsp_data !== 0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%0b err=%0b data=%h, want all 0", rsp_valid, rsp_err, rsp_data);
        end
        checks++;
        if (sp_out !== SP_INIT || req_ready !== 1) begin
            errors++;
            $display("FAIL reset_sp: sp=%h ready=%0b, want sp=%h ready=1", sp_out, req_ready, SP_INIT);
        end
        rst = 1;
        ref_stack.delete();
    endtask

    task automatic test_directed();
        dir_t        tbl[$];
        int          lat, e_lat;
        logic        err, rdy;
        bit          saw, e_err;
        logic [31:0] data, e_data, spa;
        tbl.push_back('{1'b0, 1'b0, 32'h0000_BEEF, 1'b0, 32'h0,          32'h3FE});
        tbl.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_BEEF,  32'h3FF});
        tbl.push_back('{1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0,          32'h3FD});
        tbl.push_back('{1'b1, 1'b1, 32'h0,         1'b0, 32'h1234_5678,  32'h3FF});
        tbl.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,          32'h3FF});
        tbl.push_back('{1'b1, 1'b1, 32'h0,         1'b1, 32'h0,          32'h3FF});
        for (int i = 0; i < 15; i++)
            tbl.push_back('{1'b0, 1'b0, 32'(32'hA0 + i), 1'b0, 32'h0, 32'(32'h3FE - i)});
        tbl.push_back('{1'b0, 1'b1, 32'hDEAD_0001, 1'b1, 32'h0,          32'h3F0});
        tbl.push_back('{1'b0, 1'b0, 32'h0000_00C3, 1'b0, 32'h0,          32'h3EF});
        tbl.push_back('{1'b0, 1'b0, 32'h0000_0777, 1'b1, 32'h0,          32'h3EF});
        tbl.push_back('{1'b0, 1'b1, 32'hDEAD_0002, 1'b1, 32'h0,          32'h3EF});
        tbl.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_00C3,  32'h3F0});
        tbl.push_back('{1'b1, 1'b1, 32'h0,         1'b0, 32'h00AD_00AE,  32'h3F2});
        foreach (tbl[i]) begin
            model_op(tbl[i].pop, tbl[i].two, tbl[i].wd, 0, e_err, e_data, e_lat);
            run_op(tbl[i].pop, tbl[i].two, tbl[i].wd, 0, lat, err, data, saw, spa, rdy);
            checks++;
            if (err !== tbl[i].e_err || data !== tbl[i].e_data) begin
                errors++;
                $display("FAIL dir%0d rsp: err=%0b data=%h, want err=%0b data=%h", i, err, data, tbl[i].e_err, tbl[i].e_data);
            end
            checks++;
            if (spa !== tbl[i].e_sp || rdy !== 1) begin
                errors++;
                $display("FAIL dir%0d sp: sp=%h ready=%0b, want sp=%h ready=1", i, spa, rdy, tbl[i].e_sp);
            end
            checks++;
            if (lat !== e_lat || (tbl[i].e_err && saw)) begin
                errors++;
                $display("FAIL dir%0d timing: latency=%0d mem_req_seen=%0b, want latency=%0d", i, lat, saw, e_lat);
            end
            checks++;
            if (act_log.size() != exp_log.size()) begin
                errors++;
                $display("FAIL dir%0d accesses: count=%0d, want %0d", i, act_log.size(), exp_log.size());
            end else foreach (exp_log[k])
                if (act_log[k] != exp_log[k]) begin
                    errors++;
                    $display("FAIL dir%0d access%0d: we=%0b addr=%h data=%h, want we=%0b addr=%h data=%h", i, k,
                             act_log[k].we, act_log[k].addr, act_log[k].data, exp_log[k].we, exp_log[k].addr, exp_log[k].data);
                end
        end
    endtask

    task automatic test_wait_states();
        bit          e_err, done, prev_ack, prev_req, prev_we;
        logic [31:0] e_data, prev_addr;
        int          e_lat, last_ack, rsp_cyc;
        done = 0; prev_ack = 0; prev_req = 0; prev_we = 0; prev_addr = 0;
        last_ack = -1; rsp_cyc = -1;
        model_op(1'b1, 1'b1, 32'h0, 3, e_err, e_data, e_lat);
        wait_cfg = 3;
        act_log.delete();
        req_valid = 1; req_pop = 1; req_two = 1; req_wdata = 0;
        @(posedge clk); #1;
        req_valid = 0;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            if (prev_req && !prev_ack) begin
                checks++;
                if (mem_req !== 1 || mem_addr !== prev_addr || mem_we !== prev_we) begin
                    errors++;
                    $display("FAIL wait_hold c%0d: req=%0b addr=%h we=%0b, want req=1 addr=%h we=%0b", c, mem_req, mem_addr, mem_we, prev_addr, prev_we);
                end
            end
            if (mem_req && mem_ack) last_ack = c;
            if (rsp_valid) begin
                done = 1; rsp_cyc = c;
                checks++;
                if (rsp_err !== e_err || rsp_data !== e_data) begin
                    errors++;
                    $display("FAIL wait_rsp: err=%0b data=%h, want err=%0b data=%h", rsp_err, rsp_data, e_err, e_data);
                end
            end
            prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr; prev_we = mem_we;
            if (!done) @(posedge clk);
        end
        checks++;
        if (rsp_cyc !== e_lat || last_ack < 0 || rsp_cyc !== last_ack + 1) begin
            errors++;
            $display("FAIL wait_latency: rsp cycle=%0d last ack=%0d, want rsp cycle=%0d one after ack", rsp_cyc, last_ack, e_lat);
        end
        checks++;
        if (act_log.size() != exp_log.size() || (exp_log.size() == 2 && (act_log[0] != exp_log[0] || act_log[1] != exp_log[1]))) begin
            errors++;
            $display("FAIL wait_accesses: count=%0d, want %0d in model order", act_log.size(), exp_log.size());
        end
        @(negedge clk);
        checks++;
        if (sp_out !== SP_INIT - 32'(ref_stack.size())) begin
            errors++;
            $display("FAIL wait_sp: sp=%h, want %h", sp_out, SP_INIT - 32'(ref_stack.size()));
        end
        wait_cfg = 0;
    endtask

    task automatic test_back_to_back();
        int          lat, e_lat, w;
        logic        err, rdy;
        bit          saw, e_err, pop, two;
        logic [31:0] data, e_data, spa, wd, e_sp;
        for (int i = 0; i < 60; i++) begin
            pop = ($urandom_range(0, 99) < (i < 30 ? 30 : 65));
            two = $urandom_range(0, 1);
            wd  = $urandom;
            w   = $urandom_range(0, 2);
            model_op(pop, two, wd, w, e_err, e_data, e_lat);
            e_sp = SP_INIT - 32'(ref_stack.size());
            run_op(pop, two, wd, w, lat, err, data, saw, spa, rdy);
            checks++;
            if (err !== e_err || data !== e_data || spa !== e_sp || rdy !== 1) begin
                errors++;
                $display("FAIL rnd%0d result: err=%0b data=%h sp=%h ready=%0b, want err=%0b data=%h sp=%h ready=1",
                         i, err, data, spa, rdy, e_err, e_data, e_sp);
            end
            checks++;
            if (lat !== e_lat || (e_err && saw)) begin
                errors++;
                $display("FAIL rnd%0d timing: latency=%0d mem_req_seen=%0b, want latency=%0d", i, lat, saw, e_lat);
            end
            checks++;
            if (act_log.size() != exp_log.size()) begin
                errors++;
                $display("FAIL rnd%0d accesses: count=%0d, want %0d", i, act_log.size(), exp_log.size());
            end else foreach (exp_log[k])
                if (act_log[k] != exp_log[k]) begin
                    errors++;
                    $display("FAIL rnd%0d access%0d: addr=%h data=%h, want addr=%h data=%h", i, k,
                             act_log[k].addr, act_log[k].data, exp_log[k].addr, exp_log[k].data);
                end
        end
    endtask

    task automatic test_reset_mid_op();
        int          lat, e_lat;
        logic        err, rdy;
        bit          saw, e_err, found, rsp_seen;
        logic [31:0] data, e_data, spa;
        found = 0; rsp_seen = 0;
        rst = 0;
        @(posedge clk); @(negedge clk);
        rst = 1;
        ref_stack.delete();
        model_op(1'b0, 1'b0, 32'h0000_2222, 0, e_err, e_data, e_lat);
        run_op(1'b0, 1'b0, 32'h0000_2222, 0, lat, err, data, saw, spa, rdy);
        checks++;
        if (err !== 0 || spa !== 32'h3FE) begin
            errors++;
            $display("FAIL midrst_pre: err=%0b sp=%h, want err=0 sp=3fe", err, spa);
        end
        wait_cfg = 2;
        req_valid = 1; req_pop = 0; req_two = 1; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 32'h3FD) found = 1;
            else @(posedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midrst_acc2: second access never seen, want addr 3fd");
        end
        rst = 0;
        @(posedge clk); #1;
        rst = 1;
        ref_stack.delete();
        @(negedge clk);
        checks++;
        if (mem_req !== 0 || sp_out !== SP_INIT || req_ready !== 1) begin
            errors++;
            $display("FAIL midrst_state: req=%0b sp=%h ready=%0b, want req=0 sp=%h ready=1", mem_req, sp_out, req_ready, SP_INIT);
        end
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid) rsp_seen = 1;
            @(negedge clk);
        end
        checks++;
        if (rsp_seen) begin
            errors++;
            $display("FAIL midrst_rsp: rsp_valid=1 after reset, want 0");
        end
        wait_cfg = 0;
        model_op(1'b0, 1'b0, 32'h0000_1111, 0, e_err, e_data, e_lat);
        run_op(1'b0, 1'b0, 32'h0000_1111, 0, lat, err, data, saw, spa, rdy);
        checks++;
        if (err !== 0 || spa !== 32'h3FE || lat !== e_lat || act_log.size() != 1 ||
            (act_log.size() == 1 && act_log[0] != exp_log[0])) begin
            errors++;
            $display("FAIL midrst_post: err=%0b sp=%h latency=%0d accesses=%0d, want err=0 sp=3fe latency=%0d accesses=1",
                     err, spa, lat, act_log.size(), e_lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_wait_states();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
